cpu_control: RTL and testbench

- Multi-cycle fetch/decode/execute controller and accumulator datapath for the 8-bit accumulator CPU.
- Sits directly upstream of data_memory: drives its address, mem_read, mem_write and acc inputs, and consumes its combinational data output.
- Fetches 8-bit instructions, formatted {opcode[7:4], operand[3:0]}, from a combinational instruction ROM.

---
 rtl/cpu_control.sv | 169 ++++++++++++++++
 tb/tb_cpu_control.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control.sv
// Purpose : multi-cycle fetch/decode/execute controller + accumulator datapath for the 8-bit accumulator CPU.
// Latency : 3 cycles per instruction (FETCH, DECODE, EXECUTE); results register on the EXECUTE edge.
// Backpres: none; instruction ROM and data memory are combinational, so no stalls exist.
//
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   instr_addr/data   - instruction ROM address (= PC) and combinational read data
//   address           - data-memory address (= IR operand field)
//   mem_read/write    - data-memory strobes, only ever asserted in EXECUTE
//   mem_data          - data-memory combinational read data
//   acc               - accumulator, also the data-memory write data
//   zero, carry       - acc == 0 (combinational), carry/borrow of the last ADD/SUB
//   halted            - high while in HALT
module cpu_control #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [7:0]        instr_data,
  output logic [ADDR_W-1:0] address,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] acc,
  output logic              zero,
  output logic              carry,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DECODE  = 2'd1,
    S_EXECUTE = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_LDI = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [7:0]          ir_q, ir_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                carry_q, carry_d;

  logic [3:0]          opcode;
  logic [ADDR_W-1:0]   operand;
  // One extra bit on both so the top bit is the carry out / borrow out.
  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     diff;

  assign opcode  = ir_q[7:4];
  assign operand = ir_q[ADDR_W-1:0];
  assign sum     = {1'b0, acc_q} + {1'b0, mem_data};
  assign diff    = {1'b0, acc_q} - {1'b0, mem_data};

  assign instr_addr = pc_q;
  assign address    = operand;
  assign acc        = acc_q;
  assign zero       = (acc_q == '0);
  assign carry      = carry_q;
  assign halted     = (state_q == S_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_d    = instr_data;
        pc_d    = pc_q + ADDR_W'(1);  // wraps naturally at 2^ADDR_W
        state_d = S_DECODE;
      end

      S_DECODE: begin
        state_d = S_EXECUTE;
      end

      S_EXECUTE: begin
        state_d = S_FETCH;
        case (opcode)
          OP_LDA: begin
            mem_read = 1'b1;
            acc_d    = mem_data;
          end
          OP_STA: begin
            // Memory captures acc on this edge; acc itself is untouched.
            mem_write = 1'b1;
          end
          OP_ADD: begin
            mem_read = 1'b1;
            acc_d    = sum[DATA_W-1:0];
            carry_d  = sum[DATA_W];
          end
          OP_SUB: begin
            mem_read = 1'b1;
            acc_d    = diff[DATA_W-1:0];
            carry_d  = diff[DATA_W];     // set exactly when acc < mem_data
          end
          OP_AND: begin
            mem_read = 1'b1;
            acc_d    = acc_q & mem_data;
          end
          OP_OR: begin
            mem_read = 1'b1;
            acc_d    = acc_q | mem_data;
          end
          OP_LDI: begin
            acc_d = {{(DATA_W-ADDR_W){1'b0}}, operand};
          end
          OP_JMP: begin
            pc_d = operand;
          end
          OP_JZ: begin
            // Not taken leaves the already-incremented PC in place.
            if (zero) pc_d = operand;
          end
          OP_HLT: begin
            state_d = S_HALT;
          end
          default: begin
            // NOP and the unassigned opcodes 0xA-0xE do nothing.
          end
        endcase
      end

      S_HALT: begin
        // Everything holds; only reset leaves this state.
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_control.sv
module tb_cpu_control;

  logic       clk;
  logic       rst_n;
  logic [3:0] instr_addr;
  logic [7:0] instr_data;
  logic [3:0] address;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] mem_data;
  logic [7:0] acc;
  logic       zero;
  logic       carry;
  logic       halted;

  cpu_control #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_addr (instr_addr),
    .instr_data (instr_data),
    .address    (address),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_data   (mem_data),
    .acc        (acc),
    .zero       (zero),
    .carry      (carry),
    .halted     (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction ROM and data memory models.
  logic [7:0] rom [16];
  logic [7:0] ram [16];
  logic       ram_clear;

  assign instr_data = rom[instr_addr];
  assign mem_data   = ram[address];

  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 16; i++) ram[i] <= 8'(i);
    end else if (mem_write) begin
      ram[address] <= acc;
    end
  end

  int n_cmp;
  int n_bad;
  int cyc;
  int rd_cnt;
  int wr_cnt;
  int first_wr;
  int both_cnt;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Loads a program, holds reset across one edge (re-initialising RAM to ram[i]=i),
  // and releases reset at a negedge. On return we are mid cycle 1.
  task automatic start(input logic [15:0][7:0] p);
    @(negedge clk);
    rst_n     = 1'b0;
    ram_clear = 1'b1;
    for (int i = 0; i < 16; i++) rom[i] = p[i];
    @(posedge clk);
    @(negedge clk);
    ram_clear = 1'b0;
    rst_n     = 1'b1;
    cyc       = 1;
    rd_cnt    = 0;
    wr_cnt    = 0;
    first_wr  = 0;
  endtask

  // Samples the current cycle's strobes, then advances one clock.
  task automatic step();
    if (mem_read) rd_cnt++;
    if (mem_write) begin
      wr_cnt++;
      if (first_wr == 0) first_wr = cyc;
    end
    if (mem_read && mem_write) both_cnt++;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  typedef struct packed {
    logic [15:0][7:0] prog;
    int unsigned      cycles;
    logic [7:0]       exp_acc;
    logic             exp_carry;
    logic             exp_zero;
    logic [3:0]       exp_pc;
    logic             exp_halted;
    logic [7:0]       exp_ram0;
    int unsigned      exp_rd;
    int unsigned      exp_wr;
  } vec_t;

  // p holds ROM bytes 0..7, byte 0 in the least significant position.
  function automatic vec_t mkv(input logic [7:0][7:0] p, input int unsigned c,
                               input logic [7:0] a, input logic cy, input logic z,
                               input logic [3:0] pc, input logic h, input logic [7:0] r0,
                               input int unsigned rd, input int unsigned wr);
    vec_t v;
    v.prog       = '0;
    v.prog[7:0]  = p;
    v.cycles     = c;
    v.exp_acc    = a;
    v.exp_carry  = cy;
    v.exp_zero   = z;
    v.exp_pc     = pc;
    v.exp_halted = h;
    v.exp_ram0   = r0;
    v.exp_rd     = rd;
    v.exp_wr     = wr;
    return v;
  endfunction

  localparam int NV = 11;
  vec_t vecs [NV];

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    both_cnt  = 0;
    cyc       = 0;
    rd_cnt    = 0;
    wr_cnt    = 0;
    first_wr  = 0;
    rst_n     = 1'b0;
    ram_clear = 1'b1;
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;

    //                  program                cyc  acc   c  z  pc h  ram0 rd wr
    vecs[0]  = mkv(64'h00000000_F0102015, 12, 8'h05, 0, 0, 4, 1, 8'h05, 2, 1); // LDA5 STA0 LDA0 HLT
    vecs[1]  = mkv(64'h00000000_F0433E7E, 12, 8'h19, 0, 0, 4, 1, 8'h00, 2, 0); // LDI14 ADD14 SUB3 HLT
    vecs[2]  = mkv(64'h00000000_F0314372, 12, 8'h00, 1, 1, 4, 1, 8'h00, 2, 0); // LDI2 SUB3 ADD1 HLT
    vecs[3]  = mkv(64'h0000F077_F0719470, 12, 8'h07, 0, 0, 6, 1, 8'h00, 0, 0); // JZ taken
    vecs[4]  = mkv(64'h0000F077_F0729471, 12, 8'h02, 0, 0, 4, 1, 8'h00, 0, 0); // JZ not taken
    vecs[5]  = mkv(64'h00000000_F063567C, 12, 8'h07, 0, 0, 4, 1, 8'h00, 2, 0); // LDI12 AND6 OR3
    vecs[6]  = mkv(64'h000000F0_00E2A175, 15, 8'h05, 0, 0, 5, 1, 8'h00, 0, 0); // 0xA/0xE as NOP
    vecs[7]  = mkv(64'h00000000_0071F073, 20, 8'h03, 0, 0, 2, 1, 8'h00, 0, 0); // HALT holds
    vecs[8]  = mkv(64'h00000000_00008179, 30, 8'h09, 0, 0, 1, 0, 8'h00, 0, 0); // JMP to self
    vecs[9]  = mkv(64'h00000000_00000000, 48, 8'h00, 0, 1, 3, 0, 8'h00, 0, 0); // 15 NOPs, JMP 3
    vecs[9].prog[15] = 8'h83;
    vecs[10] = mkv(64'h00000000_00000000, 48, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0); // 16 NOPs, PC wraps

    // Reset state.
    @(posedge clk);
    @(negedge clk);
    check("rst acc",        32'(acc),        32'h00);
    check("rst zero",       32'(zero),       32'h1);
    check("rst carry",      32'(carry),      32'h0);
    check("rst halted",     32'(halted),     32'h0);
    check("rst mem_read",   32'(mem_read),   32'h0);
    check("rst mem_write",  32'(mem_write),  32'h0);
    check("rst instr_addr", 32'(instr_addr), 32'h0);
    check("rst address",    32'(address),    32'h0);

    // Table-driven programs.
    for (int k = 0; k < NV; k++) begin
      start(vecs[k].prog);
      for (int unsigned c = 0; c < vecs[k].cycles; c++) step();
      check($sformatf("v%0d acc", k),    32'(acc),        32'(vecs[k].exp_acc));
      check($sformatf("v%0d carry", k),  32'(carry),      32'(vecs[k].exp_carry));
      check($sformatf("v%0d zero", k),   32'(zero),       32'(vecs[k].exp_zero));
      check($sformatf("v%0d pc", k),     32'(instr_addr), 32'(vecs[k].exp_pc));
      check($sformatf("v%0d halted", k), 32'(halted),     32'(vecs[k].exp_halted));
      check($sformatf("v%0d ram0", k),   32'(ram[0]),     32'(vecs[k].exp_ram0));
      check($sformatf("v%0d rd cnt", k), 32'(rd_cnt),     32'(vecs[k].exp_rd));
      check($sformatf("v%0d wr cnt", k), 32'(wr_cnt),     32'(vecs[k].exp_wr));
    end

    // Load/store: the only write is in cycle 6 (EXECUTE of STA).
    start(vecs[0].prog);
    for (int c = 0; c < 12; c++) step();
    check("ls wr cycle", 32'(first_wr), 32'd6);
    check("ls wr count", 32'(wr_cnt),   32'd1);

    // Arithmetic intermediates: 14, 28, 25 at the end of each EXECUTE.
    start(vecs[1].prog);
    for (int c = 0; c < 3; c++) step();
    check("ar acc after LDI", 32'(acc), 32'd14);
    for (int c = 0; c < 3; c++) step();
    check("ar acc after ADD", 32'(acc), 32'd28);
    check("ar carry after ADD", 32'(carry), 32'd0);
    for (int c = 0; c < 3; c++) step();
    check("ar acc after SUB", 32'(acc), 32'd25);
    check("ar carry after SUB", 32'(carry), 32'd0);

    // Borrow: LDI 2, SUB 3 -> 0xFF with carry set.
    start(vecs[2].prog);
    for (int c = 0; c < 6; c++) step();
    check("bw acc", 32'(acc), 32'hFF);
    check("bw carry", 32'(carry), 32'h1);
    check("bw zero", 32'(zero), 32'h0);

    // Reset during EXECUTE of STA: strobe drops at once, no write lands.
    start(64'h00000000_00F0207A);
    for (int c = 0; c < 5; c++) step();
    check("mr wr before reset", 32'(mem_write), 32'h1);
    check("mr acc before reset", 32'(acc), 32'h0A);
    #1 rst_n = 1'b0;
    #1;
    check("mr wr in reset",     32'(mem_write),  32'h0);
    check("mr acc in reset",    32'(acc),        32'h00);
    check("mr pc in reset",     32'(instr_addr), 32'h0);
    check("mr zero in reset",   32'(zero),       32'h1);
    check("mr halted in reset", 32'(halted),     32'h0);
    @(posedge clk);
    @(negedge clk);
    check("mr ram0 untouched", 32'(ram[0]), 32'h00);
    rst_n = 1'b1;
    cyc   = 1;
    check("mr refetch addr", 32'(instr_addr), 32'h0);
    step();
    check("mr pc after fetch", 32'(instr_addr), 32'h1);
    check("mr ir operand",     32'(address),    32'hA);

    check("read and write together", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
